// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: drives one DSP slice as a multiply-accumulator and returns the dot product
module dsp_mac_sequencer #(
  parameter int OPM_DLY = 1,
  parameter int P_DLY = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  len,
  output logic        busy,
  input  logic        in_valid,
  input  logic [17:0] in_a,
  input  logic [17:0] in_b,
  output logic        in_ready,
  output logic [17:0] dsp_A,
  output logic [17:0] dsp_B,
  output logic [7:0]  dsp_opmode,
  output logic        dsp_ce,
  input  logic [47:0] dsp_P,
  output logic        res_valid,
  output logic [47:0] res_data,
  input  logic        res_ready
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state;
  logic [7:0] remaining;
  logic [3:0] drain_cnt;
  logic first;
  logic issue;
  logic [7:0] opm_in;
  assign in_ready = state == RUN;
  assign issue = in_valid && in_ready;
  assign dsp_A = issue ? in_a : '0;
  assign dsp_B = issue ? in_b : '0;
  assign dsp_ce = state == RUN || state == DRAIN;
  assign busy = state != IDLE;
  assign opm_in = !dsp_ce ? 8'h00 : issue ? (first ? 8'h01 : 8'h09) : (first ? 8'h00 : 8'h08);
  generate
    if (OPM_DLY == 0) begin : g_direct
      assign dsp_opmode = opm_in;
    end else begin : g_pipe
      logic [7:0] opm_q [OPM_DLY];
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < OPM_DLY; i++) opm_q[i] <= '0;
        end else if (dsp_ce) begin
          opm_q[0] <= opm_in;
          for (int i = 1; i < OPM_DLY; i++) opm_q[i] <= opm_q[i-1];
        end
      end
      assign dsp_opmode = opm_q[OPM_DLY-1];
    end
  endgenerate
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      remaining <= '0;
      drain_cnt <= '0;
      first <= 1'b0;
      res_valid <= 1'b0;
      res_data <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          if (len != 8'd0) begin
            state <= RUN;
            remaining <= len;
            first <= 1'b1;
          end else begin
            state <= DONE;
            res_data <= '0;
            res_valid <= 1'b1;
          end
        end
        RUN: if (issue) begin
          first <= 1'b0;
          remaining <= remaining - 8'd1;
          if (remaining == 8'd1) begin
            state <= DRAIN;
            drain_cnt <= 4'(P_DLY - 1);
          end
        end
        DRAIN: if (drain_cnt == 4'd0) begin
          state <= DONE;
          res_data <= dsp_P;
          res_valid <= 1'b1;
        end else begin
          drain_cnt <= drain_cnt - 4'd1;
        end
        DONE: if (res_ready) begin
          state <= IDLE;
          res_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
